mc_controller: RTL and testbench
================================

# mc_controller

Control unit for the multicycle ARM-subset processor. A Moore main FSM sequences the shared datapath (PC register, instruction register, register file, single ALU, unified memory) through fetch, decode and execute steps. Registered condition and flag logic gates every architectural write. The block sits beside the datapath and drives all of its select and enable inputs.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  20  Instr[31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
- ALUFlags  in  4  NZCV from the ALU for the current cycle.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- RegSrc  out  2  [0]=1: RA1 = R15; [1]=1: RA2 = Rd (STR).
- ALUSrcA  out  2  00 = A (register), 01 = PC, 10/11 reserved.
- ALUSrcB  out  2  00 = register (WriteData), 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  2  equals Instr[27:26].
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR.

## Operation
- Supported instructions:
  - DP (op=00), cmd Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
  - Memory (op=01): LDR when L=Instr[20]=1, STR when L=0; address always base+imm.
  - B (op=10).
  - Any other cmd decodes as ADD with no register or flag write.
- Decode signals:
  - RegW: DP except CMP, plus LDR.
  - MemW: STR only.
  - FlagW: DP with S=Instr[20]=1. CMP always writes flags.
  - RegSrc[0] = (op==10); RegSrc[1] = (op==01).
- Condition check: combinational on cond and the Flags register. Implement all ARM codes 0000–1110. Code 1111 evaluates false.
- CondEx register: latched at the end of DECODE and held until the next DECODE. All gated writes below use this latched value, so a flag update during EXECUTE never affects the same instruction's writeback.
- Flags register (NZCV): written at the end of EXECUTER or EXECUTEI when FlagW and CondEx are both set.
  - ADD/SUB/CMP write all four flags.
  - AND/ORR write N and Z; C and V are retained.
- FSM states and outputs. Unlisted enables are 0; unlisted selects are don't-care.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10. Register reads of R15 return PC+8.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWRITE: AdrSrc=1, MemWrite=CondEx.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, decoded ALUControl.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, decoded ALUControl.
  - ALUWB: ResultSrc=00, RegWrite=RegW&CondEx.
  - BRANCH: ALUSrcA=00 with RA1=R15, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op=01→MEMADR; op=00 with I=Instr[25]=0→EXECUTER; op=00 with I=1→EXECUTEI; op=10→BRANCH; op=11→FETCH with no writes.
  - MEMADR→MEMREAD if L=1, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH→FETCH.

## Timing
- Cycles per instruction: B 3, STR 4, DP 4, LDR 5, undefined op 2.
- Reset (sampled on a clock edge):
  - State=FETCH, Flags=0000, CondEx=0.
  - While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0. Selects take their FETCH values.
- First fetch occurs in the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts it at that edge: no write issues in the reset cycle, and the next state is FETCH.
- All outputs are combinational from state plus the registered Instr, Flags and CondEx. They never depend combinationally on ALUFlags.

## Test plan
- Reset, then release -> PCWrite=1 and IRWrite=1 in cycle 1, DECODE in cycle 2; Flags=0000.
- ADDS R1,R2,#5 (0xE2921005) with R2=-5 -> EXECUTEI asserts ALUSrcB=01, ALUControl=000; Flags=0110 after that cycle; RegWrite=1 in ALUWB; 4 cycles total.
- LDR R3,[R0,#4] (0xE5903004) -> states FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); 5 cycles.
- STR R3,[R0,#8] (0xE5803008) -> RegSrc=10, MemWrite=1 only in MEMWRITE, RegWrite never asserted.
- SUBSEQ R1,R1,#1 with Z=1, result nonzero -> ALUWB still writes (CondEx latched in DECODE); BEQ next, with Z now 0 -> BRANCH with PCWrite=0.
- CMP then ANDS producing a nonzero result, with C=1 -> C and V are kept and Z clears; reset asserted during MEMREAD -> no writes, FSM restarts at FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit.
// A Moore main FSM steps the shared datapath through fetch, decode and
// execute. The condition result (CondEx) and the NZCV flags are registered,
// and every architectural write is gated by the latched CondEx.
// Outputs are decoded from the current state plus the registered Instr,
// Flags and CondEx. They never look at ALUFlags combinationally.
// The dbg_* outputs expose the FSM state, the flags and CondEx for observation.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  dbg_state_o,
  output logic [3:0]  dbg_flags_o,
  output logic        dbg_condex_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  // Instruction fields. Instr holds bits [31:12] of the instruction word.
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;   // S for data processing, L for memory
  logic [7:0] unused_rn_rd;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign i_bit        = Instr[13];
  assign cmd          = Instr[12:9];
  assign s_bit        = Instr[8];
  assign unused_rn_rd = Instr[7:0];

  // Registered state.
  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  // Decoded instruction properties.
  logic       cmd_known;
  logic       cmd_cmp;
  logic       cmd_full_nzcv;
  logic [2:0] alu_ctl_dec;
  logic       regw;
  logic       memw;
  logic       flagw;
  logic       cond_ok;

  // Decode the data-processing command and the write permissions.
  always_comb begin
    cmd_known     = 1'b0;
    cmd_cmp       = 1'b0;
    cmd_full_nzcv = 1'b0;
    alu_ctl_dec   = ALU_ADD;
    case (cmd)
      4'b0100: begin
        cmd_known     = 1'b1;
        cmd_full_nzcv = 1'b1;
        alu_ctl_dec   = ALU_ADD;
      end
      4'b0010: begin
        cmd_known     = 1'b1;
        cmd_full_nzcv = 1'b1;
        alu_ctl_dec   = ALU_SUB;
      end
      4'b0000: begin
        cmd_known   = 1'b1;
        alu_ctl_dec = ALU_AND;
      end
      4'b1100: begin
        cmd_known   = 1'b1;
        alu_ctl_dec = ALU_ORR;
      end
      4'b1010: begin
        cmd_known     = 1'b1;
        cmd_cmp       = 1'b1;
        cmd_full_nzcv = 1'b1;
        alu_ctl_dec   = ALU_SUB;
      end
      default: begin
        // Unknown commands run as ADD but never write registers or flags.
        alu_ctl_dec = ALU_ADD;
      end
    endcase

    regw  = ((op == OP_DP) && cmd_known && !cmd_cmp) ||
            ((op == OP_MEM) && s_bit);
    memw  = (op == OP_MEM) && !s_bit;
    flagw = (op == OP_DP) && cmd_known && (s_bit || cmd_cmp);
  end

  // Evaluate the condition field against the registered NZCV flags.
  always_comb begin
    logic n, z, c, v;
    n = flags_q[3];
    z = flags_q[2];
    c = flags_q[1];
    v = flags_q[0];
    case (cond)
      4'b0000: cond_ok = z;                  // EQ
      4'b0001: cond_ok = !z;                 // NE
      4'b0010: cond_ok = c;                  // CS
      4'b0011: cond_ok = !c;                 // CC
      4'b0100: cond_ok = n;                  // MI
      4'b0101: cond_ok = !n;                 // PL
      4'b0110: cond_ok = v;                  // VS
      4'b0111: cond_ok = !v;                 // VC
      4'b1000: cond_ok = c && !z;            // HI
      4'b1001: cond_ok = !c || z;            // LS
      4'b1010: cond_ok = (n == v);           // GE
      4'b1011: cond_ok = (n != v);           // LT
      4'b1100: cond_ok = !z && (n == v);     // GT
      4'b1101: cond_ok = z || (n != v);      // LE
      4'b1110: cond_ok = 1'b1;               // AL
      default: cond_ok = 1'b0;               // 1111 never executes
    endcase
  end

  // Next state, next flags and next CondEx.
  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    condex_d = condex_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // CondEx is captured here and held for the rest of the instruction.
        condex_d = cond_ok;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          OP_B:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI: begin
        state_d = S_ALUWB;
        if (flagw && condex_q) begin
          // Logic ops leave C and V alone.
          flags_d = cmd_full_nzcv ? ALUFlags : {ALUFlags[3:2], flags_q[1:0]};
        end
      end
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // State, flags and CondEx registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Moore output decode; reset shows FETCH selects with every enable low.
  always_comb begin
    state_t ctl_state;
    ctl_state  = reset ? S_FETCH : state_q;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    RegSrc     = {op == OP_MEM, op == OP_B};
    ImmSrc     = op;
    case (ctl_state)
      S_FETCH: begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = regw && condex_q;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = memw && condex_q;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = alu_ctl_dec;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctl_dec;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = regw && condex_q;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex_q;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign dbg_state_o  = state_q;
  assign dbg_flags_o  = flags_q;
  assign dbg_condex_o = condex_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed instruction sequences, a per-cycle
// expectation model built from the instruction-level behaviour, and a
// negedge compare process.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  dbg_state_o, dbg_flags_o;
  logic        dbg_condex_o;

  // Clock.
  always #5 clk = ~clk;

  mc_controller dut (
    .clk          (clk),
    .reset        (reset),
    .Instr        (Instr),
    .ALUFlags     (ALUFlags),
    .PCWrite      (PCWrite),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .IRWrite      (IRWrite),
    .AdrSrc       (AdrSrc),
    .RegSrc       (RegSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ResultSrc    (ResultSrc),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .dbg_state_o  (dbg_state_o),
    .dbg_flags_o  (dbg_flags_o),
    .dbg_condex_o (dbg_condex_o)
  );

  // Observed vector: {condex, flags, pcw, mw, rw, irw, adr, regsrc,
  // srca, srcb, ressrc, immsrc, aluctl}
  logic [22:0] got;
  assign got = {dbg_condex_o, dbg_flags_o, PCWrite, MemWrite, RegWrite,
                IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ImmSrc, ALUControl};

  // Scoreboard.
  logic [22:0] exp_q[$];
  logic [22:0] mask_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;

  // Model state.
  logic [19:0] cur_ins;
  logic [3:0]  flags_m;
  logic        condex_m;
  logic        regw_m;
  logic [2:0]  aluc_m;

  logic [22:0] ce, cm;
  string       cn;

  // Compare process: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      cm = mask_q.pop_front();
      cn = name_q.pop_front();
      tests++;
      if (((got ^ ce) & cm) != 23'd0) begin
        fails++;
        $display("FAIL %s: got %h required %h (mask %h) t=%0t",
                 cn, got & cm, ce & cm, cm, $time);
      end
    end
  end

  // Literal check against a hand-computed value.
  task automatic check_lit(input string nm, input int actual, input int required);
    tests++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, actual, required);
    end
  endtask

  // ARM condition: pairs of codes share a base test, odd code inverts.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  // Push the expectation for one named step, then advance one cycle.
  task automatic phase(input string ph);
    logic pcw, mw, rw, irw, adr;
    logic [1:0] sa, sb, res, op;
    logic [2:0] ac;
    logic m_adr, m_sa, m_sb, m_res, m_ac;
    logic [22:0] e, m;
    op = cur_ins[15:14];
    pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0;
    sa = 0; sb = 0; res = 0; ac = 0;
    m_adr = 0; m_sa = 0; m_sb = 0; m_res = 0; m_ac = 0;
    if (ph == "FETCH" || ph == "RESET") begin
      if (ph == "FETCH") begin pcw = 1; irw = 1; end
      adr = 0; sa = 2'b01; sb = 2'b10; ac = 3'b000; res = 2'b10;
      m_adr = 1; m_sa = 1; m_sb = 1; m_ac = 1; m_res = 1;
    end else if (ph == "DECODE") begin
      sa = 2'b01; sb = 2'b10; ac = 3'b000; res = 2'b10;
      m_sa = 1; m_sb = 1; m_ac = 1; m_res = 1;
    end else if (ph == "MEMADR") begin
      sa = 2'b00; sb = 2'b01; ac = 3'b000;
      m_sa = 1; m_sb = 1; m_ac = 1;
    end else if (ph == "MEMREAD") begin
      adr = 1; m_adr = 1;
    end else if (ph == "MEMWB") begin
      res = 2'b01; m_res = 1; rw = condex_m;
    end else if (ph == "MEMWRITE") begin
      adr = 1; m_adr = 1; mw = condex_m;
    end else if (ph == "EXECR" || ph == "EXECI") begin
      sa = 2'b00; sb = (ph == "EXECI") ? 2'b01 : 2'b00; ac = aluc_m;
      m_sa = 1; m_sb = 1; m_ac = 1;
    end else if (ph == "ALUWB") begin
      res = 2'b00; m_res = 1; rw = regw_m & condex_m;
    end else if (ph == "BRANCH") begin
      sa = 2'b00; sb = 2'b01; ac = 3'b000; res = 2'b10;
      m_sa = 1; m_sb = 1; m_ac = 1; m_res = 1; pcw = condex_m;
    end
    e = {condex_m, flags_m, pcw, mw, rw, irw, adr,
         {op == 2'b01, op == 2'b10}, sa, sb, res, op, ac};
    m = {1'b1, 4'hF, 4'hF, m_adr, 2'b11, {2{m_sa}}, {2{m_sb}},
         {2{m_res}}, 2'b11, {3{m_ac}}};
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(ph);
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction through the model; abort_at >= 0 asserts reset
  // in that step instead. ncyc returns the non-reset steps executed.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] aluf,
                           input int abort_at, output int ncyc);
    logic [1:0] op;
    logic       ib, sl, known, is_cmp, flagw, full;
    logic [3:0] cmd;
    string      steps[$];
    cur_ins  = ins;
    Instr    = ins;
    ALUFlags = aluf;
    op  = ins[15:14];
    ib  = ins[13];
    cmd = ins[12:9];
    sl  = ins[8];
    is_cmp = (cmd == 4'b1010);
    known  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
             (cmd == 4'b1100) || is_cmp;
    full   = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
    regw_m = ((op == 2'b00) && known && !is_cmp) || ((op == 2'b01) && sl);
    flagw  = (op == 2'b00) && known && (sl || is_cmp);
    case (cmd)
      4'b0010, 4'b1010: aluc_m = 3'b001;
      4'b0000:          aluc_m = 3'b010;
      4'b1100:          aluc_m = 3'b011;
      default:          aluc_m = 3'b000;
    endcase
    steps = {"FETCH", "DECODE"};
    case (op)
      2'b01: begin
        steps.push_back("MEMADR");
        if (sl) begin steps.push_back("MEMREAD"); steps.push_back("MEMWB"); end
        else steps.push_back("MEMWRITE");
      end
      2'b00: begin
        steps.push_back(ib ? "EXECI" : "EXECR");
        steps.push_back("ALUWB");
      end
      2'b10: steps.push_back("BRANCH");
      default: ;
    endcase
    ncyc = 0;
    for (int i = 0; i < steps.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        phase("RESET");
        flags_m  = 4'b0000;
        condex_m = 1'b0;
        reset    = 1'b0;
        break;
      end
      phase(steps[i]);
      ncyc++;
      if (steps[i] == "DECODE") condex_m = cond_true(ins[19:16], flags_m);
      if ((steps[i] == "EXECR" || steps[i] == "EXECI") && flagw && condex_m)
        flags_m = full ? aluf : {aluf[3:2], flags_m[1:0]};
    end
  endtask

  int n;

  // Directed stimulus.
  initial begin
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    cur_ins  = 20'h0;
    flags_m  = 4'b0000;
    condex_m = 1'b0;
    regw_m   = 1'b0;
    aluc_m   = 3'b000;
    @(posedge clk);
    #1;
    phase("RESET");
    phase("RESET");
    reset = 1'b0;
    check_lit("reset_flags", int'(dbg_flags_o), 0);

    // ADDS R1,R2,#5 with R2=-5: result zero with carry out.
    run_instr(20'hE2921, 4'b0110, -1, n);
    check_lit("adds_cycles", n, 4);
    check_lit("adds_flags", int'(dbg_flags_o), 4'b0110);

    // LDR R3,[R0,#4]
    run_instr(20'hE5903, 4'b0000, -1, n);
    check_lit("ldr_cycles", n, 5);

    // STR R3,[R0,#8]
    run_instr(20'hE5803, 4'b0000, -1, n);
    check_lit("str_cycles", n, 4);

    // SUBSEQ R1,R1,#1 with Z=1, result nonzero.
    run_instr(20'h02511, 4'b0010, -1, n);
    check_lit("subseq_cycles", n, 4);
    check_lit("subseq_flags", int'(dbg_flags_o), 4'b0010);
    check_lit("subseq_condex", int'(dbg_condex_o), 1);

    // BEQ with Z now 0: branch not taken.
    run_instr(20'h0A000, 4'b0000, -1, n);
    check_lit("beq_cycles", n, 3);
    check_lit("beq_condex", int'(dbg_condex_o), 0);

    // CMP R0,#imm producing N=1 C=1 V=1.
    run_instr(20'hE3500, 4'b1011, -1, n);
    check_lit("cmp_flags", int'(dbg_flags_o), 4'b1011);

    // ANDS R2,R1,#imm nonzero: N,Z from ALU, C,V kept.
    run_instr(20'hE2112, 4'b0000, -1, n);
    check_lit("ands_flags", int'(dbg_flags_o), 4'b0011);

    // Unsupported cmd with S=1: runs as ADD, no register or flag write.
    run_instr(20'hE3F10, 4'b1111, -1, n);
    check_lit("undef_cmd_flags", int'(dbg_flags_o), 4'b0011);

    // ORRNE R4,R5,R6 (register form, no S).
    run_instr(20'h11854, 4'b1000, -1, n);
    check_lit("orrne_flags", int'(dbg_flags_o), 4'b0011);

    // LDR with cond 1111: never executes.
    run_instr(20'hF5903, 4'b0000, -1, n);
    check_lit("ldr_nv_condex", int'(dbg_condex_o), 0);

    // Undefined op 11.
    run_instr(20'hEC000, 4'b0000, -1, n);
    check_lit("undef_op_cycles", n, 2);

    // LDR aborted by reset in MEMREAD.
    run_instr(20'hE5903, 4'b0000, 3, n);
    check_lit("abort_steps", n, 3);
    check_lit("abort_flags", int'(dbg_flags_o), 0);

    // ADD R1,R2,R3 after the abort.
    run_instr(20'hE0821, 4'b0000, -1, n);
    check_lit("add_after_reset_cycles", n, 4);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
